// File: rtl/rr_stream_arbiter.sv
// N-way packet-stream arbiter: round-robin or fixed-priority selection, grant held
// for a whole packet, optional forced release after MAX_BEATS transfers.
module rr_stream_arbiter #(
  parameter  int WIDTH     = 8,
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_BEATS = 0,
  localparam int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] data_in,
  input  logic [NUM_REQ-1:0]       last_in,
  input  logic                     mode,
  input  logic                     out_ready,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       accept,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic [SRC_W-1:0]         out_src
);

  localparam int BEAT_W = ($clog2(MAX_BEATS + 1) < 1) ? 1 : $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t              state, state_nxt;
  logic [NUM_REQ-1:0]  grant_nxt;
  logic [SRC_W-1:0]    src_nxt;
  logic [SRC_W-1:0]    rr_ptr, rr_ptr_nxt;
  logic [BEAT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic [SRC_W-1:0]    rr_win, fx_win, win;
  logic                rr_found;
  logic                owner_req, owner_last, xfer, cap_hit;
  logic [WIDTH-1:0]    owner_data;

  // Owner view is muxed by the one-hot grant, so it is all-zero while idle.
  always_comb begin
    owner_req  = 1'b0;
    owner_last = 1'b0;
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        owner_req  = req[i];
        owner_last = last_in[i];
        owner_data = data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!rr_found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        rr_win   = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
        rr_found = 1'b1;
      end
    end
    fx_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) fx_win = SRC_W'(k);
    end
  end

  assign win     = mode ? fx_win : rr_win;
  assign xfer    = owner_req & out_ready;
  assign cap_hit = (MAX_BEATS != 0) && ((int'(beat_cnt) + 1) == MAX_BEATS);

  assign accept    = grant & {NUM_REQ{out_ready}};
  assign out_valid = owner_req;
  assign out_data  = owner_req ? owner_data : '0;
  assign out_last  = owner_req & owner_last;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    src_nxt      = out_src;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt    = OWN;
          grant_nxt    = NUM_REQ'(1) << win;
          src_nxt      = win;
          beat_cnt_nxt = '0;
        end
      end
      OWN: begin
        // Withdrawal, end of packet or beat cap all release on this edge.
        if (!owner_req || (xfer && (owner_last || cap_hit))) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          rr_ptr_nxt = (out_src == SRC_W'(NUM_REQ - 1)) ? '0 : out_src + 1'b1;
        end else if (xfer) begin
          beat_cnt_nxt = beat_cnt + BEAT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state    <= IDLE;
      grant    <= '0;
      out_src  <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      out_src  <= src_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
Parametrised N-way arbiter that multiplexes NUM_REQ packet streams onto one output stream with a valid/ready handshake. It supports round-robin or fixed-priority selection, holds the grant for a whole packet (until `last`), and can force a release after MAX_BEATS beats. It is the generalised successor of the fixed 3-input arbiter and sits in front of shared sinks such as a bus master port or a shared FIFO.

Parameters:
- WIDTH, 8, data width per channel in bits.
- NUM_REQ, 4, number of requesting channels (>=2).
- MAX_BEATS, 0, maximum beats per grant; 0 = unlimited (release only on `last`).
- SRC_W, $clog2(NUM_REQ), width of the source index (localparam, not overridable).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- res  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-channel valid; bit i means channel i presents a beat.
- data_in  in  NUM_REQ*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- last_in  in  NUM_REQ  per-channel end-of-packet flag, qualified by req[i].
- mode  in  1  0 = round-robin, 1 = fixed priority (channel 0 highest).
- out_ready  in  1  downstream ready.
- grant  out  NUM_REQ  registered one-hot ownership; all zero when idle.
- accept  out  NUM_REQ  combinational per-channel ready: accept[i] = grant[i] & out_ready.
- out_valid  out  1  equals req[w] while a grant is held; else 0.
- out_data  out  WIDTH  data_in slice of the owner w when out_valid=1; else 0.
- out_last  out  1  last_in[w] when out_valid=1; else 0.
- out_src  out  SRC_W  registered index w of the current owner; holds its last value when idle.

Behaviour:
- Reset (async, res=1): state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, out_src=0. Therefore out_valid=0, out_data=0, out_last=0, accept=0. Reset asserted mid-packet aborts the packet immediately; no beat is accepted while res=1.
- FSM with two states, IDLE and OWN.
- In IDLE:
  - If req != 0, pick winner w. Round-robin: first set bit searching upward from rr_ptr with wrap at NUM_REQ-1 -> 0. Fixed: lowest set index.
  - mode is sampled only here.
  - Next cycle: grant = one-hot(w), out_src = w, beat_cnt = 0, state = OWN.
  - If req == 0, stay in IDLE.
- Arbitration latency: req rises in cycle n (IDLE) -> grant high in cycle n+1. There is no combinational path from req to grant.
- In OWN:
  - A beat transfers when req[w] & out_ready.
  - Each transfer increments beat_cnt (width $clog2(MAX_BEATS+1), min 1).
- Release (same edge as the triggering event -> state=IDLE, grant=0, rr_ptr = (w+1) mod NUM_REQ):
  - (a) transfer with last_in[w]=1;
  - (b) MAX_BEATS != 0 and the transfer makes beat_cnt reach MAX_BEATS;
  - (c) req[w]=0 (owner withdrew; no transfer that cycle).
- After any release, exactly one IDLE cycle precedes the next grant (one-cycle bubble between packets).
- rr_ptr updates on every release in both modes. In fixed mode it is not used.
- Requests from non-owners are ignored while in OWN; they hold their request and are never dropped by the block.
- Back-pressure: out_ready=0 stalls the beat. Grant is held, beat_cnt is unchanged, out_data/out_last stay driven from channel w.
- A single-beat packet (last_in=1 on the first beat) releases after one transfer.
- NUM_REQ that is not a power of two: rr_ptr wraps at NUM_REQ-1. out_src never exceeds NUM_REQ-1.

Test Plan:
- Reset then req=4'b0000 for 10 cycles -> grant=0, out_valid=0, out_data=0 throughout.
- mode=0, req=4'b1111, every beat has last_in=1, out_ready=1 -> owners 0,1,2,3,0 in order; grant one-hot; one idle cycle between grants.
- mode=1, req=4'b1110 held, single-beat packets -> channel 1 wins every time; channels 2 and 3 are starved as specified.
- Channel 2 sends a 4-beat packet (data 0xA0..0xA3, last on the 4th), out_ready low on beat 2 for 3 cycles -> out_data holds 0xA1 during the stall; 4 transfers total; channel 0 requesting concurrently is granted only after release plus one idle cycle.
- MAX_BEATS=2, channel 1 streams 5 beats without last -> forced release after 2 beats; the next grant goes round-robin to the next requester. Channel 1 regains the grant only on its turn.
- Assert res for one cycle mid-packet (grant=4'b0100) -> grant and out_valid drop asynchronously; after deassertion, arbitration restarts from rr_ptr=0.
